// File: rtl/fetch_buffer_if.sv
// Bundle of the fetch-side PC/data signals and the decode-side valid/ready
// signals that surround the fetch buffer.
interface fetch_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] io_pc;
    logic [XLEN-1:0] io_imem_rdata;
    logic            io_flush;
    logic            io_stall_en;
    logic            io_out_valid;
    logic            io_out_ready;
    logic [XLEN-1:0] io_out_pc;
    logic [XLEN-1:0] io_out_instr;
    logic [CW-1:0]   io_count;

    // master: fetch unit / imem / decode environment
    modport master (
        output io_pc, io_imem_rdata, io_flush, io_out_ready,
        input  io_stall_en, io_out_valid, io_out_pc, io_out_instr, io_count
    );

    // slave: the fetch buffer itself
    modport slave (
        input  io_pc, io_imem_rdata, io_flush, io_out_ready,
        output io_stall_en, io_out_valid, io_out_pc, io_out_instr, io_count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: tracks the single in-flight imem request, queues {pc, instr}
// pairs for decode and throttles the fetch unit with a credit-style stall.
module fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]     count_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic              req_vld_reg;
    logic [XLEN-1:0]   req_pc_reg;
    logic [2*XLEN-1:0] entry_q [DEPTH];

    logic [CW:0] load;
    logic        stall;
    logic        issue;
    logic        push;
    logic        pop;
    logic        out_valid;

    // Stall counts the in-flight request as already occupying a slot, so a
    // push can never land in a full FIFO.
    assign load      = (CW + 1)'(count_reg) + (CW + 1)'(req_vld_reg);
    assign stall     = reset & (load >= (CW + 1)'(DEPTH));
    assign issue     = reset & ~stall & ~bus.io_flush;
    assign push      = req_vld_reg & ~bus.io_flush;
    assign out_valid = reset & (count_reg != '0) & ~bus.io_flush;
    assign pop       = out_valid & bus.io_out_ready;

    assign bus.io_stall_en  = stall;
    assign bus.io_out_valid = out_valid;
    assign bus.io_count     = count_reg;
    assign bus.io_out_pc    = entry_q[rd_ptr_reg][2*XLEN-1:XLEN];
    assign bus.io_out_instr = entry_q[rd_ptr_reg][XLEN-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [2*XLEN-1:0] entry_reg;

            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= {req_pc_reg, bus.io_imem_rdata};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg   <= '0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            req_vld_reg <= 1'b0;
        end else if (bus.io_flush) begin
            // Redirect: drop queued entries and any data returning this cycle.
            count_reg   <= '0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            req_vld_reg <= 1'b0;
        end else begin
            req_vld_reg <= issue;
            if (issue) begin
                req_pc_reg <= bus.io_pc;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised and directed bench for fetch_buffer against a queue-based model
// of the fetch/imem/decode interaction.
module tb_fetch_buffer;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clock;
    logic reset;

    fetch_buffer_if #(.XLEN(32), .DEPTH(4)) fb ();

    fetch_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (fb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem: one-cycle read latency, content derived from the address
    always @(posedge clock) fb.io_imem_rdata <= fb.io_pc ^ KEY;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq[$];
    logic [31:0] delivered[$];
    bit          pend;
    logic [31:0] pend_pc;
    bit          armed = 0;
    bit          exp_valid;
    bit          exp_stall;

    always @(negedge clock) begin
        if (armed) begin
            exp_valid = reset && (mq.size() != 0) && !fb.io_flush;
            exp_stall = reset && ((mq.size() + int'(pend)) >= 4);
            chk("count", 64'(fb.io_count), 64'(mq.size()));
            chk("out_valid", 64'(fb.io_out_valid), 64'(exp_valid));
            chk("stall_en", 64'(fb.io_stall_en), 64'(exp_stall));
            if (exp_valid && fb.io_out_valid) begin
                chk("head", {fb.io_out_pc, fb.io_out_instr}, mq[0]);
            end
            if (fb.io_count > 4) chk("count_range", 64'(fb.io_count), 64'd4);
        end
        if (fb.io_out_valid === 1'b1 && fb.io_out_ready === 1'b1 && reset === 1'b1) begin
            delivered.push_back(fb.io_out_pc);
            $display("pop pc=%08h instr=%08h count=%0d", fb.io_out_pc, fb.io_out_instr, fb.io_count);
        end
        if (reset === 1'b0) begin
            mq.delete();
            pend  = 0;
            armed = 1;
        end else if (armed) begin
            if (fb.io_flush) begin
                mq.delete();
                pend = 0;
            end else begin
                exp_stall = (mq.size() + int'(pend)) >= 4;
                if (exp_valid && fb.io_out_ready) void'(mq.pop_front());
                if (pend) begin
                    if (mq.size() >= 4) chk("push_into_full", 64'(mq.size()), 64'd3);
                    mq.push_back({pend_pc, pend_pc ^ KEY});
                end
                pend    = !exp_stall;
                pend_pc = fb.io_pc;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] tgt;
    logic        stall_s;

    task automatic drive(input bit r, input bit f, input logic [31:0] t, input bit rd);
        reset           = r;
        fb.io_flush     = f;
        tgt             = t;
        fb.io_out_ready = rd;
        #2;
        stall_s = fb.io_stall_en;
    endtask

    // Fetch unit: redirect on flush, hold on stall, otherwise PC+4.
    task automatic advance();
        @(posedge clock);
        #1;
        if (!reset)              fb.io_pc = 32'h0;
        else if (fb.io_flush)    fb.io_pc = tgt;
        else if (!stall_s)       fb.io_pc = fb.io_pc + 32'd4;
    endtask

    task automatic tick(input bit r, input bit f, input logic [31:0] t, input bit rd);
        drive(r, f, t, rd);
        advance();
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    bit ok;
    int base;

    initial begin
        reset           = 1'b0;
        fb.io_flush     = 1'b0;
        fb.io_out_ready = 1'b0;
        fb.io_pc        = 32'h0;
        tgt             = 32'h0;
        @(posedge clock);
        #1;

        // 1: streaming with ready held high
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 0, 1);
            if (c == 1) chk("t1_valid_c1", 64'(fb.io_out_valid), 64'd0);
            if (c == 2) begin
                chk("t1_valid_c2", 64'(fb.io_out_valid), 64'd1);
                chk("t1_pc_c2", 64'(fb.io_out_pc), 64'h0);
                chk("t1_instr_c2", 64'(fb.io_out_instr), 64'hA5A5_0000);
            end
            if (c >= 3) chk("t1_pc_seq", 64'(fb.io_out_pc), 64'((c - 2) * 4));
            advance();
        end

        // 2: backpressure fills the FIFO, then drains in order
        do_reset();
        delivered.delete();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 0, 0);
            if (c == 9) begin
                chk("t2_count_full", 64'(fb.io_count), 64'd4);
                chk("t2_stall", 64'(fb.io_stall_en), 64'd1);
                chk("t2_pc_held", 64'(fb.io_pc), 64'd16);
            end
            advance();
        end
        for (int c = 0; c < 10; c++) tick(1, 0, 0, 1);
        chk("t2_delivered_n", 64'(delivered.size() >= 5), 64'd1);
        if (delivered.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t2_order", 64'(delivered[i]), 64'(i * 4));

        // 3: flush with three queued and one in flight
        do_reset();
        for (int c = 0; c < 4; c++) tick(1, 0, 0, 0);
        drive(1, 1, 32'h100, 0);
        chk("t3_count_pre", 64'(fb.io_count), 64'd3);
        advance();
        delivered.delete();
        drive(1, 0, 0, 1);
        chk("t3_count_post", 64'(fb.io_count), 64'd0);
        chk("t3_valid_post", 64'(fb.io_out_valid), 64'd0);
        advance();
        for (int c = 0; c < 8; c++) tick(1, 0, 0, 1);
        chk("t3_delivered_n", 64'(delivered.size() >= 1), 64'd1);
        if (delivered.size() >= 1) chk("t3_first", 64'(delivered[0]), 64'h100);
        ok = 1;
        foreach (delivered[i]) if (delivered[i] < 32'h100) ok = 0;
        chk("t3_no_wrong_path", 64'(ok), 64'd1);

        // 4: flush while the head is being accepted
        do_reset();
        for (int c = 0; c < 5; c++) tick(1, 0, 0, 1);
        drive(1, 1, 32'h200, 1);
        chk("t4_valid_in_flush", 64'(fb.io_out_valid), 64'd0);
        advance();
        delivered.delete();
        drive(1, 0, 0, 1);
        chk("t4_count_post", 64'(fb.io_count), 64'd0);
        advance();
        for (int c = 0; c < 6; c++) tick(1, 0, 0, 1);
        if (delivered.size() >= 1) chk("t4_first", 64'(delivered[0]), 64'h200);
        else chk("t4_delivered_n", 64'(delivered.size()), 64'd1);

        // 5: ready toggling across pointer wrap
        do_reset();
        delivered.delete();
        for (int c = 0; c < 40; c++) tick(1, 0, 0, (c % 2) == 0);
        chk("t5_delivered_n", 64'(delivered.size() >= 12), 64'd1);
        if (delivered.size() >= 12)
            for (int i = 0; i < 12; i++) chk("t5_order", 64'(delivered[i]), 64'(i * 4));

        // 6: one-cycle reset pulse with entries queued
        do_reset();
        for (int c = 0; c < 4; c++) tick(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t6_count_pre", 64'(fb.io_count), 64'd3);
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 0, 1);
            if (c == 0) begin
                chk("t6_count", 64'(fb.io_count), 64'd0);
                chk("t6_valid", 64'(fb.io_out_valid), 64'd0);
                chk("t6_stall", 64'(fb.io_stall_en), 64'd0);
            end
            if (c == 2) begin
                chk("t6_valid_c2", 64'(fb.io_out_valid), 64'd1);
                chk("t6_pc_c2", 64'(fb.io_out_pc), 64'h0);
            end
            advance();
        end

        // random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            tick($urandom_range(0, 99) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom & 32'h0000_FFFC,
                 $urandom_range(0, 2) != 0);
        end
        tick(1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
